regs_wb_arbiter: RTL
====================

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 Parameter: DW, 32, write-data width.
REQ-002 Parameter: AW, 5, register-address width (2^AW registers).
REQ-003 Port: Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: Reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: A_Req  input  1  requester A write request, held until granted.
REQ-006 Port: A_Addr  input  AW  requester A destination register.
REQ-007 Port: A_Data  input  DW  requester A write data.
REQ-008 Port: A_Gnt  output  1  requester A accepted this cycle (combinational).
REQ-009 Port: B_Req / B_Addr / B_Data / B_Gnt shall mirror REQ-005..008 for requester B.
REQ-010 Port: Clr_Start  input  1  request to zero all registers.
REQ-011 Port: Busy  output  1  clear sequence in progress.
REQ-012 Port: Clr_Done  output  1  one-cycle pulse on the final clear write.
REQ-013 Port: Write_reg  output  1  register-file write enable, registered.
REQ-014 Port: W_Addr  output  AW  register-file write address, registered.
REQ-015 Port: W_Data  output  DW  register-file write data, registered.

Function
REQ-016 States shall be IDLE and CLEAR; Busy shall equal (state==CLEAR).
REQ-017 A transfer shall occur in a cycle where X_Req and X_Gnt are both high; at most one Gnt shall be high per cycle.
REQ-018 X_Gnt shall be high only when state==IDLE, Clr_Start==0 and X_Req==1, with the other requester not winning arbitration.
REQ-019 Arbitration shall be round-robin: a 1-bit priority pointer selects the winner when both request; after any grant the pointer shall point to the non-granted requester.
REQ-020 A lone requester shall be granted the same cycle regardless of pointer; the pointer still updates per REQ-019.
REQ-021 A transfer in cycle t shall produce Write_reg=1, W_Addr=X_Addr, W_Data=X_Data in cycle t+1 (latency 1).
REQ-022 A granted transfer with X_Addr==0 shall be consumed but shall produce Write_reg=0 in t+1 (register 0 is hard-wired zero).
REQ-023 Cycles with no transfer and not in CLEAR shall drive Write_reg=0; W_Addr/W_Data hold their last values.
REQ-024 Clr_Start==1 in IDLE at cycle t shall suppress all grants in t and enter CLEAR at t+1.
REQ-025 In CLEAR, a 5-bit counter shall drive Write_reg=1, W_Addr=0,1,...,2^AW-1, W_Data=0 in cycles t+1..t+2^AW, one address per cycle, no gaps.
REQ-026 Clr_Done shall be high only in the cycle W_Addr==2^AW-1 is driven by the clear; state shall return to IDLE the following cycle and the counter shall wrap to 0.
REQ-027 Clr_Start in CLEAR shall be ignored; it shall not restart or extend the sequence.
REQ-028 Requests asserted during CLEAR shall remain pending (Gnt low) and be arbitrated normally from the first IDLE cycle.
REQ-029 Clr_Start held high continuously shall start a new sequence on each IDLE cycle it is sampled, starving requesters (caller's responsibility).

Reset
REQ-030 Reset_n low shall immediately force state=IDLE, counter=0, pointer=A, Write_reg=0, W_Addr=0, W_Data=0, Busy=0, Clr_Done=0, independent of Clk.
REQ-031 Reset mid-CLEAR shall abort the sequence with no Clr_Done pulse; no write shall issue until a new request or Clr_Start after release.
REQ-032 Gnt outputs shall be 0 while Reset_n is low.

Verification
REQ-033 Reset then A_Req=1, A_Addr=5, A_Data=0x1234 for one cycle -> A_Gnt=1 same cycle; next cycle Write_reg=1, W_Addr=5, W_Data=0x1234.
REQ-034 A and B request continuously from reset (A_Addr=1, B_Addr=2) -> grants A,B,A,B...; W_Addr sequence 1,2,1,2 one cycle later.
REQ-035 Clr_Start pulse at t with B_Req=1 -> B_Gnt=0 at t; Busy=1 t+1..t+32; W_Addr 0..31, W_Data=0; Clr_Done only at t+32; B_Gnt=1 at t+33.
REQ-036 A_Req with A_Addr=0, A_Data=0xFFFFFFFF -> A_Gnt=1; next cycle Write_reg=0.
REQ-037 Reset_n low at t+10 during a clear -> outputs zero immediately, Clr_Done never pulses; after release Busy=0 and Write_reg=0 with no inputs.
REQ-038 Clr_Start re-pulsed at t+5 during CLEAR -> sequence ends at t+32 unchanged, exactly 32 clear writes.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regs_wb_arbiter
// Purpose  : Round-robin write arbiter for two requesters into a register
//            file, with a sequenced clear-all-registers operation.
// Revision : 1.0  initial release
// ============================================================================
module regs_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          A_Req,
    input  logic [AW-1:0] A_Addr,
    input  logic [DW-1:0] A_Data,
    output logic          A_Gnt,
    input  logic          B_Req,
    input  logic [AW-1:0] B_Addr,
    input  logic [DW-1:0] B_Data,
    output logic          B_Gnt,
    input  logic          Clr_Start,
    output logic          Busy,
    output logic          Clr_Done,
    output logic          Write_reg,
    output logic [AW-1:0] W_Addr,
    output logic [DW-1:0] W_Data
);

    localparam logic [0:0]    c_IDLE  = 1'b0;
    localparam logic [0:0]    c_CLEAR = 1'b1;
    localparam logic [AW-1:0] c_LAST  = '1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ptr;      // 0: A has priority, 1: B has priority
    logic          r_write;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    logic w_arb_en;
    logic w_a_gnt;
    logic w_b_gnt;

    // Grants are gated by reset so nothing is accepted while held in reset.
    assign w_arb_en = Reset_n && (r_state == c_IDLE) && !Clr_Start;
    assign w_a_gnt  = w_arb_en && A_Req && (!B_Req || !r_ptr);
    assign w_b_gnt  = w_arb_en && B_Req && (!A_Req ||  r_ptr);

    assign A_Gnt     = w_a_gnt;
    assign B_Gnt     = w_b_gnt;
    assign Busy      = (r_state == c_CLEAR);
    assign Clr_Done  = (r_state == c_CLEAR) && (r_cnt == c_LAST);
    assign Write_reg = r_write;
    assign W_Addr    = r_waddr;
    assign W_Data    = r_wdata;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_write <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_write <= 1'b0;
            if (r_state == c_IDLE) begin
                if (Clr_Start) begin
                    r_state <= c_CLEAR;
                    r_cnt   <= '0;
                    r_write <= 1'b1;
                    r_waddr <= '0;
                    r_wdata <= '0;
                end else if (w_a_gnt) begin
                    r_ptr   <= 1'b1;
                    r_write <= (A_Addr != '0);   // register 0 is hard-wired zero
                    r_waddr <= A_Addr;
                    r_wdata <= A_Data;
                end else if (w_b_gnt) begin
                    r_ptr   <= 1'b0;
                    r_write <= (B_Addr != '0);
                    r_waddr <= B_Addr;
                    r_wdata <= B_Data;
                end
            end else begin
                // r_cnt tracks the address currently on W_Addr and wraps to 0.
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_state <= c_IDLE;
                end else begin
                    r_write <= 1'b1;
                    r_waddr <= r_cnt + 1'b1;
                    r_wdata <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
